// File: rtl/decimal_entry_encoder.sv
// ============================================================================
// decimal_entry_encoder - strobed decimal keypad entry to signed 15-bit value
// Optional idle auto-clear when DIGIT_TIMEOUT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module decimal_entry_encoder #(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        CLK_50,
  input  logic        RST_N,
  input  logic        digit_strobe,
  input  logic [3:0]  digit,
  input  logic        neg_strobe,
  input  logic        clear_strobe,
  input  logic        enter_strobe,
  output logic        digit_ready,
  output logic [13:0] entry_mag,
  output logic        entry_neg,
  output logic [2:0]  digit_count,
  output logic [14:0] value,
  output logic        value_valid,
  output logic        overflow,
  output logic        bad_digit
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_MUL    = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  if (MAX_DIGITS < 1 || MAX_DIGITS > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 67108864) begin : g_param_check
    $error("decimal_entry_encoder: illegal MAX_DIGITS or TIMEOUT_CYCLES");
  end

  logic [1:0]  state_q, state_d;
  logic [13:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  dig_q, dig_d;
  logic [14:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        bad_q, bad_d;
  logic        w_clear;
  logic [14:0] w_mag_ext;

`ifdef DIGIT_TIMEOUT_EN
  localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);

  logic [25:0] tmo_q, tmo_d;
  logic        w_any_strobe;
  logic        w_tmo_run;
  logic        w_tmo_fire;

  // An empty but signed entry still counts as in-progress and may time out.
  assign w_any_strobe = digit_strobe | neg_strobe | clear_strobe | enter_strobe;
  assign w_tmo_run    = (state_q == S_ENTRY) || ((state_q == S_IDLE) && neg_q);
  assign w_tmo_fire   = w_tmo_run && !w_any_strobe && (tmo_q == TMO_LAST);
  assign tmo_d        = (w_tmo_run && !w_any_strobe && !w_tmo_fire) ? tmo_q + 26'd1 : 26'd0;
  assign w_clear      = clear_strobe | w_tmo_fire;

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) tmo_q <= 26'd0;
    else        tmo_q <= tmo_d;
  end
`else
  assign w_clear = clear_strobe;
`endif

  assign w_mag_ext = {1'b0, mag_q};

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    value_d = value_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    bad_d   = 1'b0;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (w_clear) begin
          mag_d   = 14'd0;
          neg_d   = 1'b0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end else if (enter_strobe) begin
          state_d = S_COMMIT;
        end else if (neg_strobe) begin
          neg_d = ~neg_q;
        end else if (digit_strobe) begin
          if (digit > 4'd9) begin
            bad_d = 1'b1;
          end else if (cnt_q >= MAX_CNT) begin
            ovf_d = 1'b1;
          end else begin
            dig_d   = digit;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (clear_strobe) begin
          mag_d   = 14'd0;
          neg_d   = 1'b0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          // mag*10 as shift-add; at most 999*10+9, so 14 bits never overflow.
          mag_d   = {mag_q[10:0], 3'b000} + {mag_q[12:0], 1'b0} + {10'd0, dig_q};
          cnt_d   = cnt_q + 3'd1;
          state_d = S_ENTRY;
        end
      end
      S_COMMIT: begin
        // A clear arriving here lands on the same end state, so the commit always completes.
        value_d = neg_q ? (~w_mag_ext + 15'd1) : w_mag_ext;
        valid_d = 1'b1;
        mag_d   = 14'd0;
        neg_d   = 1'b0;
        cnt_d   = 3'd0;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      mag_q   <= 14'd0;
      neg_q   <= 1'b0;
      cnt_q   <= 3'd0;
      dig_q   <= 4'd0;
      value_q <= 15'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      value_q <= value_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign digit_ready = (state_q == S_IDLE) || (state_q == S_ENTRY);
  assign entry_mag   = mag_q;
  assign entry_neg   = neg_q;
  assign digit_count = cnt_q;
  assign value       = value_q;
  assign value_valid = valid_q;
  assign overflow    = ovf_q;
  assign bad_digit   = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_decimal_entry_encoder.sv
// ============================================================================
// tb_decimal_entry_encoder - directed self-checking bench for decimal_entry_encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decimal_entry_encoder;

  logic        CLK_50;
  logic        RST_N;
  logic        digit_strobe;
  logic [3:0]  digit;
  logic        neg_strobe;
  logic        clear_strobe;
  logic        enter_strobe;
  logic        digit_ready;
  logic [13:0] entry_mag;
  logic        entry_neg;
  logic [2:0]  digit_count;
  logic [14:0] value;
  logic        value_valid;
  logic        overflow;
  logic        bad_digit;

  int checks;
  int errors;

  decimal_entry_encoder #(
    .MAX_DIGITS     (4),
    .TIMEOUT_CYCLES (50000000)
  ) u_dut (
    .CLK_50       (CLK_50),
    .RST_N        (RST_N),
    .digit_strobe (digit_strobe),
    .digit        (digit),
    .neg_strobe   (neg_strobe),
    .clear_strobe (clear_strobe),
    .enter_strobe (enter_strobe),
    .digit_ready  (digit_ready),
    .entry_mag    (entry_mag),
    .entry_neg    (entry_neg),
    .digit_count  (digit_count),
    .value        (value),
    .value_valid  (value_valid),
    .overflow     (overflow),
    .bad_digit    (bad_digit)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  task automatic tick();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Digit strobe plus the following MUL cycle.
  task automatic key(input logic [3:0] d);
    digit_strobe = 1'b1;
    digit        = d;
    tick();
    digit_strobe = 1'b0;
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    RST_N        = 1'b0;
    digit_strobe = 1'b0;
    digit        = 4'd0;
    neg_strobe   = 1'b0;
    clear_strobe = 1'b0;
    enter_strobe = 1'b0;
    tick();
    tick();
    chk("rst_mag",   32'(entry_mag),   32'd0);
    chk("rst_neg",   32'(entry_neg),   32'd0);
    chk("rst_cnt",   32'(digit_count), 32'd0);
    chk("rst_value", 32'(value),       32'd0);
    chk("rst_valid", 32'(value_valid), 32'd0);
    chk("rst_ovf",   32'(overflow),    32'd0);
    chk("rst_bad",   32'(bad_digit),   32'd0);
    chk("rst_ready", 32'(digit_ready), 32'd1);
    RST_N = 1'b1;
    tick();

    // 1,2,3,4 then enter
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("t1_mag", 32'(entry_mag),   32'd1234);
    chk("t1_cnt", 32'(digit_count), 32'd4);
    enter_strobe = 1'b1; tick(); enter_strobe = 1'b0;
    chk("t1_commit_ready", 32'(digit_ready), 32'd0);
    chk("t1_valid_early",  32'(value_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(value_valid), 32'd1);
    chk("t1_value", 32'(value),       32'd1234);
    chk("t1_mag0",  32'(entry_mag),   32'd0);
    chk("t1_cnt0",  32'(digit_count), 32'd0);
    tick();
    chk("t1_valid_once", 32'(value_valid), 32'd0);
    chk("t1_value_hold", 32'(value),       32'd1234);

    // neg, 9999, overflowing fifth digit, enter
    neg_strobe = 1'b1; tick(); neg_strobe = 1'b0;
    chk("t2_neg",   32'(entry_neg),   32'd1);
    chk("t2_ready", 32'(digit_ready), 32'd1);
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    digit_strobe = 1'b1; digit = 4'd5; tick(); digit_strobe = 1'b0;
    chk("t2_ovf",   32'(overflow),    32'd1);
    chk("t2_mag",   32'(entry_mag),   32'd9999);
    chk("t2_cnt",   32'(digit_count), 32'd4);
    chk("t2_ready_full", 32'(digit_ready), 32'd1);
    tick();
    enter_strobe = 1'b1; tick(); enter_strobe = 1'b0;
    tick();
    chk("t2_value",  32'(value),       32'h58F1);
    chk("t2_valid",  32'(value_valid), 32'd1);
    chk("t2_ovf0",   32'(overflow),    32'd0);
    chk("t2_neg0",   32'(entry_neg),   32'd0);

    // digit during MUL is dropped
    digit_strobe = 1'b1; digit = 4'd7; tick();
    chk("t3_ready_mul", 32'(digit_ready), 32'd0);
    digit = 4'd3; tick(); digit_strobe = 1'b0;
    chk("t3_mag", 32'(entry_mag),   32'd7);
    chk("t3_cnt", 32'(digit_count), 32'd1);
    enter_strobe = 1'b1; tick(); enter_strobe = 1'b0;
    tick();
    chk("t3_value", 32'(value), 32'd7);

    // bad digit, then signed empty entry commits zero
    digit_strobe = 1'b1; digit = 4'hC; tick(); digit_strobe = 1'b0;
    chk("t4_bad",   32'(bad_digit),   32'd1);
    chk("t4_mag",   32'(entry_mag),   32'd0);
    chk("t4_cnt",   32'(digit_count), 32'd0);
    chk("t4_ready", 32'(digit_ready), 32'd1);
    tick();
    chk("t4_bad_pulse", 32'(bad_digit), 32'd0);
    neg_strobe = 1'b1; tick(); neg_strobe = 1'b0;
    enter_strobe = 1'b1; tick(); enter_strobe = 1'b0;
    tick();
    chk("t4_value", 32'(value),       32'd0);
    chk("t4_valid", 32'(value_valid), 32'd1);

    // enter beats neg in the same cycle
    key(4'd3);
    neg_strobe = 1'b1; enter_strobe = 1'b1; tick();
    neg_strobe = 1'b0; enter_strobe = 1'b0;
    tick();
    chk("t5_value", 32'(value), 32'd3);

    // clear during COMMIT lets the commit complete
    key(4'd6);
    enter_strobe = 1'b1; tick(); enter_strobe = 1'b0;
    clear_strobe = 1'b1; tick(); clear_strobe = 1'b0;
    chk("t6_value", 32'(value),       32'd6);
    chk("t6_valid", 32'(value_valid), 32'd1);
    chk("t6_ready", 32'(digit_ready), 32'd1);

    // clear beats enter
    key(4'd4); key(4'd2);
    chk("t7_mag", 32'(entry_mag), 32'd42);
    clear_strobe = 1'b1; enter_strobe = 1'b1; tick();
    clear_strobe = 1'b0; enter_strobe = 1'b0;
    chk("t7_mag0",  32'(entry_mag),   32'd0);
    chk("t7_cnt0",  32'(digit_count), 32'd0);
    chk("t7_ready", 32'(digit_ready), 32'd1);
    chk("t7_valid", 32'(value_valid), 32'd0);
    tick();
    chk("t7_valid2", 32'(value_valid), 32'd0);
    chk("t7_value",  32'(value),       32'd6);

    // asynchronous reset in the middle of MUL
    key(4'd1);
    digit_strobe = 1'b1; digit = 4'd8; tick(); digit_strobe = 1'b0;
    chk("t8_pre_ready", 32'(digit_ready), 32'd0);
    #2 RST_N = 1'b0;
    #1;
    chk("t8_mag",   32'(entry_mag),   32'd0);
    chk("t8_cnt",   32'(digit_count), 32'd0);
    chk("t8_value", 32'(value),       32'd0);
    chk("t8_ready", 32'(digit_ready), 32'd1);
    tick();
    RST_N = 1'b1;
    tick();

    // entry persists across a long idle period
    key(4'd5);
    repeat (100) tick();
    chk("t9_mag", 32'(entry_mag),   32'd5);
    chk("t9_cnt", 32'(digit_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
